uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Controller for the serial receiver. Owns the operating-mode byte and derives the
//  receiver's baud divisor. Enables and quiesces the receiver around configuration
//  changes, buffers received bytes in a small FIFO, drives RTS flow control with
//  hysteresis and keeps sticky error flags. Sits between the receiver and the consumer.
// PARAMETERS
//  DEPTH    4   FIFO entries; power of two, 2..16
//  RTS_HI   3   count >= RTS_HI drops RTS
//  RTS_LO   1   count <= RTS_LO raises RTS; RTS_LO < RTS_HI
// PORTS
//  Clock        in   1   system clock, 50 MHz
//  Reset_n      in   1   asynchronous, active-low reset
//  cfg_we       in   1   one-cycle write strobe for the mode byte
//  cfg_data     in   8   [7:6] baud sel, [5] 1=one stop bit, [1] parity odd, [0] parity en
//  cfg_busy     out  1   a configuration write is pending and not yet applied
//  mode         out  8   mode byte currently applied to the receiver
//  baud_div     out  16  clocks per bit for the receiver
//  rx_en        out  1   receiver enable
//  rx_busy      in   1   receiver is mid-frame
//  rx_valid     in   1   one-cycle pulse: rx_byte and error flags valid
//  rx_byte      in   8   received byte
//  rx_par_err   in   1   parity mismatch; ignored when mode[0]=0
//  rx_frm_err   in   1   stop bit sampled low
//  out_valid    out  1   FIFO not empty
//  out_data     out  8   FIFO head; valid while out_valid=1
//  out_ready    in   1   consumer pop; pop happens when out_valid & out_ready
//  RTS          out  1   1 = peer may send
//  err_status   out  3   sticky flags: [0] parity, [1] framing, [2] overrun
//  err_clr      in   1   clears err_status
//  fifo_count   out  $clog2(DEPTH)+1   current FIFO occupancy
// BEHAVIOUR
//  Reset values: state=CFG, mode=8'h00, baud_div=10416, rx_en=0, RTS=0, cfg_busy=0,
//   err_status=0, fifo_count=0, out_valid=0, out_data=0.
//  Baud table (50 MHz): 00->10416, 01->5208, 10->2604, 11->868.
//   baud_div updates in the same cycle mode updates.
//  FSM, all outputs registered:
//   CFG: rx_en=0, RTS=0. cfg_we -> latch cfg_data into mode -> ARM next cycle.
//   ARM: rx_en=1. rx_busy=1 -> FRAME. cfg_we -> set cfg_busy, go QUIESCE.
//   FRAME: rx_en=1. rx_valid -> push, then ARM (or QUIESCE if cfg_busy).
//    cfg_we here sets cfg_busy and holds the pending byte. A later cfg_we overwrites it.
//   QUIESCE: rx_en=0, RTS=0. Wait rx_busy=0. Apply pending mode, clear cfg_busy -> ARM.
//    A frame completing here is still pushed.
//  RTS, valid only in ARM/FRAME:
//   Falls the cycle after fifo_count >= RTS_HI. Rises the cycle after fifo_count <= RTS_LO.
//   Otherwise holds its value.
//  FIFO is first-word fall-through. out_data reflects the head combinationally from storage.
//   Push and pop in the same cycle: count unchanged.
//   When full, push+pop together still accepts the push.
//   Push when full without pop: byte dropped, err_status[2] set.
//   Pop when empty: ignored.
//  Errors: on rx_valid, set [0] if rx_par_err & mode[0], set [1] if rx_frm_err.
//   Bytes with errors are still pushed.
//   err_clr clears all bits. A set in the same cycle wins over the clear.
//  Count arithmetic uses $clog2(DEPTH)+1 bits. Pointers are $clog2(DEPTH) bits and wrap naturally.
//  Reset mid-operation: all state returns to reset values immediately; FIFO contents are discarded.
// STRUCTURE
//  Package uart_pkg: state encoding (CFG, ARM, FRAME, QUIESCE), baud table constants,
//   mode-bit index localparams, error-bit indices.
//  Sub-module uart_byte_fifo (DEPTH, WIDTH=8): storage, pointers, count, full/empty.
//   The controller keeps the FSM, RTS logic, baud decode and error register.
// TESTING
//  1 Reset, cfg_we with 8'hB5 -> next cycle mode=B5, baud_div=2604, rx_en=1, RTS=1.
//  2 Three rx_valid pulses (8'h41, 8'h42, 8'h43), out_ready=0 -> count=3, RTS=0 the next cycle.
//    Pop two -> RTS=1 once count=1; out_data order 41, 42, 43.
//  3 Fill to 4, then rx_valid with 8'h55 and no pop -> byte dropped, err_status=3'b100.
//    Repeat with out_ready=1 in the same cycle -> 55 accepted, count stays 4.
//  4 cfg_we with 8'hC1 while rx_busy=1 -> cfg_busy=1, mode unchanged until rx_valid and rx_busy=0.
//    Then mode=C1, baud_div=868.
//  5 rx_valid with rx_par_err=1, mode[0]=0 -> err_status=0.
//    With mode[0]=1 plus err_clr in the same cycle -> err_status[0]=1.
//  6 Assert Reset_n=0 mid-FRAME with count=2 -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings and constants for the UART receive controller.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_CFG     = 2'd0,
        ST_ARM     = 2'd1,
        ST_FRAME   = 2'd2,
        ST_QUIESCE = 2'd3
    } state_e;

    localparam int unsigned MODE_W = 8;
    localparam int unsigned BAUD_W = 16;
    localparam int unsigned ERR_W  = 3;

    // Clocks per bit at a 50 MHz system clock
    localparam logic [BAUD_W-1:0] BAUD_DIV_4800  = 16'd10416;
    localparam logic [BAUD_W-1:0] BAUD_DIV_9600  = 16'd5208;
    localparam logic [BAUD_W-1:0] BAUD_DIV_19200 = 16'd2604;
    localparam logic [BAUD_W-1:0] BAUD_DIV_57600 = 16'd868;

    // Mode byte field positions
    localparam int unsigned MODE_BAUD_HI = 7;
    localparam int unsigned MODE_BAUD_LO = 6;
    localparam int unsigned MODE_STOP1   = 5;
    localparam int unsigned MODE_PAR_ODD = 1;
    localparam int unsigned MODE_PAR_EN  = 0;

    // Sticky error flag positions
    localparam int unsigned ERR_PAR = 0;
    localparam int unsigned ERR_FRM = 1;
    localparam int unsigned ERR_OVR = 2;

    // Baud select field to divisor
    function automatic logic [BAUD_W-1:0] baud_decode(input logic [1:0] sel);
        logic [BAUD_W-1:0] div;
        case (sel)
            2'b00:   div = BAUD_DIV_4800;
            2'b01:   div = BAUD_DIV_9600;
            2'b10:   div = BAUD_DIV_19200;
            default: div = BAUD_DIV_57600;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word fall-through byte FIFO; a push into a full FIFO is accepted only alongside a pop.
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty_c,
    output logic                     overrun_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full_c;
    logic             do_push;
    logic             do_pop;

    assign empty_c     = (count == '0);
    assign full_c      = (count == CNT_W'(DEPTH));
    assign do_pop      = pop & ~empty_c;
    assign do_push     = push & (~full_c | do_pop);
    assign overrun_c   = push & full_c & ~pop;
    assign head_data_c = mem[rd_ptr];

    // Storage write
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receiver controller: mode/baud ownership, enable sequencing, byte buffering, RTS and error flags.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned RTS_HI = 3,
    parameter int unsigned RTS_LO = 1
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic                   cfg_we,
    input  logic [7:0]             cfg_data,
    output logic                   cfg_busy,
    output logic [7:0]             mode,
    output logic [15:0]            baud_div,
    output logic                   rx_en,
    input  logic                   rx_busy,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_par_err,
    input  logic                   rx_frm_err,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    input  logic                   out_ready,
    output logic                   RTS,
    output logic [2:0]             err_status,
    input  logic                   err_clr,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] RTS_HI_C = CNT_W'(RTS_HI);
    localparam logic [CNT_W-1:0] RTS_LO_C = CNT_W'(RTS_LO);

    state_e              state_q;
    state_e              state_d;
    logic [MODE_W-1:0]   pending_q;
    logic [MODE_W-1:0]   pending_d;
    logic [MODE_W-1:0]   mode_d;
    logic [MODE_W-1:0]   apply_byte;
    logic [BAUD_W-1:0]   baud_d;
    logic                cfg_busy_d;
    logic                rx_en_d;
    logic                rts_d;
    logic [ERR_W-1:0]    err_d;
    logic                rx_accept;
    logic                fifo_empty;
    logic                fifo_overrun;

    uart_byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .push        (rx_accept),
        .push_data   (rx_byte),
        .pop         (out_ready),
        .head_data_c (out_data),
        .count       (fifo_count),
        .empty_c     (fifo_empty),
        .overrun_c   (fifo_overrun)
    );

    assign out_valid = ~fifo_empty;

    // Registered state and outputs
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_CFG;
            pending_q  <= '0;
            mode       <= '0;
            baud_div   <= BAUD_DIV_4800;
            cfg_busy   <= 1'b0;
            rx_en      <= 1'b0;
            RTS        <= 1'b0;
            err_status <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mode       <= mode_d;
            baud_div   <= baud_d;
            cfg_busy   <= cfg_busy_d;
            rx_en      <= rx_en_d;
            RTS        <= rts_d;
            err_status <= err_d;
        end
    end

    // Next state, configuration sequencing, receiver enable and RTS hysteresis
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        mode_d     = mode;
        baud_d     = baud_div;
        cfg_busy_d = cfg_busy;
        rx_accept  = 1'b0;
        apply_byte = cfg_we ? cfg_data : pending_q;

        case (state_q)
            ST_CFG: begin
                if (cfg_we) begin
                    mode_d  = cfg_data;
                    baud_d  = baud_decode(cfg_data[MODE_BAUD_HI:MODE_BAUD_LO]);
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                rx_accept = rx_valid;
                if (cfg_we) begin
                    pending_d  = cfg_data;
                    cfg_busy_d = 1'b1;
                    state_d    = ST_QUIESCE;
                end else if (rx_busy) begin
                    state_d = ST_FRAME;
                end
            end
            ST_FRAME: begin
                rx_accept = rx_valid;
                if (cfg_we) begin
                    pending_d  = cfg_data;
                    cfg_busy_d = 1'b1;
                end
                if (rx_valid) begin
                    state_d = (cfg_busy || cfg_we) ? ST_QUIESCE : ST_ARM;
                end
            end
            ST_QUIESCE: begin
                rx_accept = rx_valid;
                if (cfg_we) begin
                    pending_d = cfg_data;
                end
                if (!rx_busy) begin
                    mode_d     = apply_byte;
                    baud_d     = baud_decode(apply_byte[MODE_BAUD_HI:MODE_BAUD_LO]);
                    cfg_busy_d = 1'b0;
                    state_d    = ST_ARM;
                end
            end
            default: begin
                state_d = ST_CFG;
            end
        endcase

        rx_en_d = (state_d == ST_ARM) || (state_d == ST_FRAME);

        if (!rx_en_d) begin
            rts_d = 1'b0;
        end else if (fifo_count >= RTS_HI_C) begin
            rts_d = 1'b0;
        end else if (fifo_count <= RTS_LO_C) begin
            rts_d = 1'b1;
        end else begin
            rts_d = RTS;
        end
    end

    // Sticky error flags; a new set beats a simultaneous clear
    always_comb begin
        err_d = err_clr ? '0 : err_status;
        if (rx_accept && rx_par_err && mode[MODE_PAR_EN]) begin
            err_d[ERR_PAR] = 1'b1;
        end
        if (rx_accept && rx_frm_err) begin
            err_d[ERR_FRM] = 1'b1;
        end
        if (fifo_overrun) begin
            err_d[ERR_OVR] = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue-based reference model checked every cycle, plus directed literal checks.
module tb_uart_rx_ctrl;

    localparam int DEPTH  = 4;
    localparam int RTS_HI = 3;
    localparam int RTS_LO = 1;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_data = '0;
    logic        cfg_busy;
    logic [7:0]  mode;
    logic [15:0] baud_div;
    logic        rx_en;
    logic        rx_busy = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        rx_par_err = 1'b0;
    logic        rx_frm_err = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        RTS;
    logic [2:0]  err_status;
    logic        err_clr = 1'b0;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    // Expectations the stimulus declares for the coming clock edge
    logic       en_next = 1'b0;
    logic       busy_next = 1'b0;
    logic       apply = 1'b0;
    logic [7:0] apply_val = '0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_mode = '0;
    logic [2:0] m_err = '0;
    logic       m_rts = 1'b0;
    logic       m_en = 1'b0;
    logic       m_busy = 1'b0;
    int         m_n;
    bit         m_full;
    bit         m_pop;
    logic [2:0] m_e;

    uart_rx_ctrl #(
        .DEPTH  (DEPTH),
        .RTS_HI (RTS_HI),
        .RTS_LO (RTS_LO)
    ) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .cfg_we     (cfg_we),
        .cfg_data   (cfg_data),
        .cfg_busy   (cfg_busy),
        .mode       (mode),
        .baud_div   (baud_div),
        .rx_en      (rx_en),
        .rx_busy    (rx_busy),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_par_err (rx_par_err),
        .rx_frm_err (rx_frm_err),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .RTS        (RTS),
        .err_status (err_status),
        .err_clr    (err_clr),
        .fifo_count (fifo_count)
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] baud_of(input logic [1:0] s);
        case (s)
            2'b00:   return 16'd10416;
            2'b01:   return 16'd5208;
            2'b10:   return 16'd2604;
            default: return 16'd868;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte queue, sticky flags, hysteresis on pre-edge occupancy
    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            q.delete();
            m_mode = '0;
            m_err  = '0;
            m_rts  = 1'b0;
            m_en   = 1'b0;
            m_busy = 1'b0;
        end else begin
            m_n    = q.size();
            m_full = (m_n == DEPTH);
            m_pop  = out_ready && (m_n > 0);
            m_e    = err_clr ? 3'b000 : m_err;
            if (rx_valid) begin
                if (rx_par_err && m_mode[0]) m_e[0] = 1'b1;
                if (rx_frm_err) m_e[1] = 1'b1;
                if (m_full && !m_pop) m_e[2] = 1'b1;
            end
            m_err = m_e;
            if (!en_next) m_rts = 1'b0;
            else if (m_n >= RTS_HI) m_rts = 1'b0;
            else if (m_n <= RTS_LO) m_rts = 1'b1;
            if (m_pop) void'(q.pop_front());
            if (rx_valid && (!m_full || m_pop)) q.push_back(rx_byte);
            m_en   = en_next;
            m_busy = busy_next;
            if (apply) m_mode = apply_val;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge Clock) begin
        chk("mode", 32'(mode), 32'(m_mode));
        chk("baud_div", 32'(baud_div), 32'(baud_of(m_mode[7:6])));
        chk("rx_en", 32'(rx_en), 32'(m_en));
        chk("cfg_busy", 32'(cfg_busy), 32'(m_busy));
        chk("RTS", 32'(RTS), 32'(m_rts));
        chk("err_status", 32'(err_status), 32'(m_err));
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // One receiver frame: busy cycle, then the valid cycle with optional pop/clear
    task automatic frame(input logic [7:0] b, input logic par, input logic frm,
                         input logic pop, input logic clr);
        rx_busy = 1'b1;
        tick();
        rx_valid = 1'b1; rx_byte = b; rx_par_err = par; rx_frm_err = frm;
        rx_busy = 1'b0; out_ready = pop; err_clr = clr;
        tick();
        rx_valid = 1'b0; rx_par_err = 1'b0; rx_frm_err = 1'b0;
        out_ready = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_mode", 32'(mode), 32'h00);
        chk("rst_baud", 32'(baud_div), 32'd10416);
        chk("rst_rx_en", 32'(rx_en), 32'd0);
        chk("rst_rts", 32'(RTS), 32'd0);
        Reset_n = 1'b1;
        tick();

        // 1: configure B5 from CFG
        cfg_we = 1'b1; cfg_data = 8'hB5;
        en_next = 1'b1; apply = 1'b1; apply_val = 8'hB5;
        tick();
        cfg_we = 1'b0; apply = 1'b0;
        chk("t1_mode", 32'(mode), 32'hB5);
        chk("t1_baud", 32'(baud_div), 32'd2604);
        chk("t1_rx_en", 32'(rx_en), 32'd1);
        chk("t1_rts", 32'(RTS), 32'd1);

        // 2: three bytes, no pop; RTS drops, then rises after draining to one
        frame(8'h41, 0, 0, 0, 0);
        frame(8'h42, 0, 0, 0, 0);
        frame(8'h43, 0, 0, 0, 0);
        chk("t2_count3", 32'(fifo_count), 32'd3);
        tick();
        chk("t2_rts_low", 32'(RTS), 32'd0);
        chk("t2_head41", 32'(out_data), 32'h41);
        out_ready = 1'b1;
        tick();
        chk("t2_head42", 32'(out_data), 32'h42);
        tick();
        out_ready = 1'b0;
        chk("t2_count1", 32'(fifo_count), 32'd1);
        chk("t2_rts_still_low", 32'(RTS), 32'd0);
        tick();
        chk("t2_rts_high", 32'(RTS), 32'd1);
        chk("t2_head43", 32'(out_data), 32'h43);

        // 3: fill, overrun drop, then push+pop while full
        frame(8'h44, 0, 0, 0, 0);
        frame(8'h45, 0, 0, 0, 0);
        frame(8'h46, 0, 0, 0, 0);
        chk("t3_full", 32'(fifo_count), 32'd4);
        frame(8'h55, 0, 0, 0, 0);
        chk("t3_drop_count", 32'(fifo_count), 32'd4);
        chk("t3_overrun", 32'(err_status), 32'b100);
        chk("t3_head43", 32'(out_data), 32'h43);
        frame(8'h55, 0, 0, 1, 0);
        chk("t3_pushpop_count", 32'(fifo_count), 32'd4);
        chk("t3_head44", 32'(out_data), 32'h44);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        chk("t3_drained", 32'(out_valid), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_clr", 32'(err_status), 32'd0);

        // Reconfigure to 40 (parity off) from ARM
        cfg_we = 1'b1; cfg_data = 8'h40; busy_next = 1'b1; en_next = 1'b0;
        tick();
        cfg_we = 1'b0;
        chk("cfg_arm_busy", 32'(cfg_busy), 32'd1);
        chk("cfg_arm_rx_en", 32'(rx_en), 32'd0);
        apply = 1'b1; apply_val = 8'h40; busy_next = 1'b0; en_next = 1'b1;
        tick();
        apply = 1'b0;
        chk("cfg_arm_mode", 32'(mode), 32'h40);
        chk("cfg_arm_baud", 32'(baud_div), 32'd5208);

        // 5a: parity error ignored with parity disabled
        frame(8'h60, 1, 0, 0, 0);
        chk("t5_par_ignored", 32'(err_status), 32'd0);

        // 4: configuration write mid-frame is deferred
        rx_busy = 1'b1;
        tick();
        cfg_we = 1'b1; cfg_data = 8'hC1; busy_next = 1'b1;
        tick();
        cfg_we = 1'b0;
        chk("t4_busy", 32'(cfg_busy), 32'd1);
        chk("t4_mode_held", 32'(mode), 32'h40);
        tick();
        chk("t4_mode_held2", 32'(mode), 32'h40);
        rx_valid = 1'b1; rx_byte = 8'h77; rx_busy = 1'b0; en_next = 1'b0;
        tick();
        rx_valid = 1'b0;
        chk("t4_quiesce_rx_en", 32'(rx_en), 32'd0);
        chk("t4_quiesce_mode", 32'(mode), 32'h40);
        apply = 1'b1; apply_val = 8'hC1; busy_next = 1'b0; en_next = 1'b1;
        tick();
        apply = 1'b0;
        chk("t4_mode", 32'(mode), 32'hC1);
        chk("t4_baud", 32'(baud_div), 32'd868);
        chk("t4_busy_clr", 32'(cfg_busy), 32'd0);
        chk("t4_count", 32'(fifo_count), 32'd2);

        // 5b: framing flag, then parity set beating a simultaneous clear
        frame(8'h99, 0, 1, 0, 0);
        chk("t5_frm", 32'(err_status), 32'b010);
        frame(8'h88, 1, 0, 0, 1);
        chk("t5_par_wins", 32'(err_status), 32'b001);

        // 6: asynchronous reset mid-frame with two bytes buffered
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        chk("t6_count2", 32'(fifo_count), 32'd2);
        rx_busy = 1'b1;
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        chk("t6_mode", 32'(mode), 32'h00);
        chk("t6_baud", 32'(baud_div), 32'd10416);
        chk("t6_rx_en", 32'(rx_en), 32'd0);
        chk("t6_rts", 32'(RTS), 32'd0);
        chk("t6_busy", 32'(cfg_busy), 32'd0);
        chk("t6_err", 32'(err_status), 32'd0);
        chk("t6_count", 32'(fifo_count), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_data", 32'(out_data), 32'd0);
        rx_busy = 1'b0; en_next = 1'b0; busy_next = 1'b0;
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        repeat (2) tick();
        chk("t6_post_rx_en", 32'(rx_en), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
